serial_subtractor: RTL and testbench

- Bit-serial, LSB-first N-bit subtractor computing diff = a - b with a borrow flip-flop.
- Sequential counterpart to the combinational adder cells in comb_logic; it is the subtract direction of the same arithmetic.
- Operands are loaded in parallel on a start handshake, processed one bit per clock, and returned in parallel with a one-cycle done pulse.
- Intended for area-constrained datapaths where latency is acceptable.

---
 rtl/serial_subtractor.sv | 170 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial, LSB-first unsigned subtractor: diff = a - b (mod 2^WIDTH).
// Operands are loaded in parallel when start is accepted, one bit is resolved
// per clock through a single borrow flip-flop, and the result is published in
// parallel together with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, the ovf port exists and reports two's-complement overflow
//   of the subtraction. When undefined, the port and its logic are absent.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset (priority over start)
//   start  in   request; accepted only on an edge where ready=1
//   a      in   minuend, sampled on the accepting edge
//   b      in   subtrahend, sampled on the accepting edge
//   ready  out  block can accept start this cycle (IDLE or DONE)
//   done   out  single-cycle pulse; diff/borrow(/ovf) are valid
//   diff   out  a - b modulo 2^WIDTH, held until the next completion
//   borrow out  1 when a < b (unsigned), held like diff
//   ovf    out  signed overflow, held like diff (SERIAL_SUB_OVF_EN only)
//
// Handshake: a request transfers on a rising edge where start=1 and ready=1.
// start while ready=0 is ignored; nothing is queued. Completion is signalled
// by done for exactly one cycle, during which ready=1 so a new request can be
// accepted back-to-back.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             borrow,
   output logic             ovf
`else
   output logic             borrow
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    count;

   logic             accept;
   logic             last;
   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUB_OVF_EN
   // Operand MSBs are shifted out of a_sr/b_sr during RUN, so keep copies.
   logic             a_msb;
   logic             b_msb;
`endif

   // Full-subtractor cell on the current LSBs.
   assign d_bit     = a_sr[0] ^ b_sr[0] ^ br;
   assign br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
   assign res_shift = {d_bit, res_sr[WIDTH-1:1]};
   assign last      = (count == LAST_CNT);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      ready      = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            ready  = 1'b1;
            accept = start;
            if (start) next_state = RUN;
         end
         RUN: begin
            if (last) next_state = DONE;
         end
         DONE: begin
            ready      = 1'b1;
            done       = 1'b1;
            accept     = start;
            next_state = start ? RUN : IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: shift registers, borrow FF, bit counter, held outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         count  <= '0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else if (accept) begin
         a_sr   <= a;
         b_sr   <= b;
         res_sr <= '0;
         br     <= 1'b0;
         count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_shift;
         br     <= br_next;
         if (last) begin
            // Completing edge: publish the result; count parks at WIDTH-1.
            diff   <= res_shift;
            borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= (a_msb != b_msb) && (res_shift[WIDTH-1] != a_msb);
`endif
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Bench for serial_subtractor (WIDTH=8). Expected results are pushed to
// queues when a request is driven and popped when done is observed.
// Define SERIAL_SUB_OVF_EN for both files to exercise the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp;
  int n_fail;

  logic [W-1:0] exp_q[$];
  logic         exp_b_q[$];
  logic         exp_o_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
    .borrow (borrow),
    .ovf    (ovf)
`else
    .borrow (borrow)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // driver: push expectation, issue one request, wait (bounded) for done
  // ---------------------------------------------------------------------------
  task automatic push_exp(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    logic [W-1:0] d;
    d = op_a - op_b;
    exp_q.push_back(d);
    exp_b_q.push_back(op_a < op_b);
    exp_o_q.push_back((op_a[W-1] != op_b[W-1]) && (d[W-1] != op_a[W-1]));
  endtask

  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        output logic rdy0, output bit seen, output int lat,
                        output logic [W-1:0] got_d, output logic got_b,
                        output logic got_o, output logic done_after);
    @(negedge clk);
    rdy0  = ready;
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    push_exp(op_a, op_b);
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 0;
    lat   = 0;
    got_d = '0;
    got_b = 1'b0;
    got_o = 1'b0;
    for (int i = 0; i < 3 * W && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) begin
        seen  = 1;
        got_d = diff;
        got_b = borrow;
`ifdef SERIAL_SUB_OVF_EN
        got_o = ovf;
`endif
      end
    end
    @(negedge clk);
    done_after = done;
  endtask

  // ---------------------------------------------------------------------------
  // tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got=%h exp=00", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
  endtask

  task automatic test_arith();
    logic [W-1:0] ta[$];
    logic [W-1:0] tb_[$];
    logic         rdy0, got_b, got_o, done_after, eb;
    logic [W-1:0] got_d, ed;
    bit           seen;
    int           lat;
    ta  = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'hA5, 8'h80, 8'h7F};
    tb_ = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hA5, 8'h01, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      ta.push_back(W'($urandom_range(0, 255)));
      tb_.push_back(W'($urandom_range(0, 255)));
    end
    for (int i = 0; i < ta.size(); i++) begin
      run_op(ta[i], tb_[i], rdy0, seen, lat, got_d, got_b, got_o, done_after);
      ed = exp_q.pop_front();
      eb = exp_b_q.pop_front();
      void'(exp_o_q.pop_front());
      n_cmp++;
      if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL arith_ready op%0d got=%b exp=1", i, rdy0); end
      n_cmp++;
      if (!seen) begin
        n_fail++; $display("FAIL arith_timeout op%0d a=%h b=%h no done within %0d cycles", i, ta[i], tb_[i], 3 * W);
      end else begin
        n_cmp++;
        if (lat !== W) begin n_fail++; $display("FAIL arith_latency op%0d got=%0d exp=%0d", i, lat, W); end
        n_cmp++;
        if (got_d !== ed) begin n_fail++; $display("FAIL arith_diff op%0d a=%h b=%h got=%h exp=%h", i, ta[i], tb_[i], got_d, ed); end
        n_cmp++;
        if (got_b !== eb) begin n_fail++; $display("FAIL arith_borrow op%0d a=%h b=%h got=%b exp=%b", i, ta[i], tb_[i], got_b, eb); end
        n_cmp++;
        if (done_after !== 1'b0) begin n_fail++; $display("FAIL arith_done_width op%0d got=%b exp=0", i, done_after); end
        // result must be held into IDLE
        n_cmp++;
        if (diff !== ed) begin n_fail++; $display("FAIL arith_hold op%0d got=%h exp=%h", i, diff, ed); end
      end
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] ta[3];
    logic [W-1:0] tb_[3];
    logic         rdy0, got_b, got_o, done_after, eb, eo;
    logic [W-1:0] got_d, ed;
    bit           seen;
    int           lat;
    ta  = '{8'h80, 8'h7F, 8'h05};
    tb_ = '{8'h01, 8'hFF, 8'h03};
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb_[i], rdy0, seen, lat, got_d, got_b, got_o, done_after);
      ed = exp_q.pop_front();
      eb = exp_b_q.pop_front();
      eo = exp_o_q.pop_front();
      n_cmp++;
      if (!seen) begin
        n_fail++; $display("FAIL ovf_timeout op%0d no done", i);
      end else begin
        n_cmp++;
        if (got_d !== ed) begin n_fail++; $display("FAIL ovf_diff op%0d got=%h exp=%h", i, got_d, ed); end
        n_cmp++;
        if (got_b !== eb) begin n_fail++; $display("FAIL ovf_borrow op%0d got=%b exp=%b", i, got_b, eb); end
        n_cmp++;
        if (got_o !== eo) begin n_fail++; $display("FAIL ovf_flag op%0d a=%h b=%h got=%b exp=%b", i, ta[i], tb_[i], got_o, eo); end
      end
    end
  endtask
`endif

  // start held across both accepting edges; operands are 0x00 during RUN and
  // 0x10/0x01 only at the accepting edges, so any re-sampling shows up.
  task automatic test_back_to_back();
    int           k;
    int           n_done;
    int           done_k[$];
    logic [W-1:0] ed;
    logic         eb;
    push_exp(8'h10, 8'h01);
    push_exp(8'h10, 8'h01);
    @(negedge clk);
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    k      = -1;
    n_done = 0;
    while (k < 30) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (done) begin
        n_done++;
        done_k.push_back(k);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL b2b_extra_done at k=%0d diff=%h", k, diff);
        end else begin
          ed = exp_q.pop_front();
          eb = exp_b_q.pop_front();
          void'(exp_o_q.pop_front());
          n_cmp++;
          if (diff !== ed) begin n_fail++; $display("FAIL b2b_diff k=%0d got=%h exp=%h", k, diff, ed); end
          n_cmp++;
          if (borrow !== eb) begin n_fail++; $display("FAIL b2b_borrow k=%0d got=%b exp=%b", k, borrow, eb); end
        end
      end
      if (k + 1 == W + 1) begin
        a = 8'h10;
        b = 8'h01;
      end else begin
        a = 8'h00;
        b = 8'h00;
      end
      start = (k + 1 <= 2 * W + 1);
    end
    start = 1'b0;
    n_cmp++;
    if (n_done !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", n_done); end
    if (done_k.size() == 2) begin
      n_cmp++;
      if (done_k[0] !== W) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=%0d", done_k[0], W); end
      n_cmp++;
      if (done_k[1] - done_k[0] !== W + 1) begin
        n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", done_k[1] - done_k[0], W + 1);
      end
    end
    while (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(exp_b_q.pop_front());
      void'(exp_o_q.pop_front());
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    @(negedge clk);
    a     = 8'h40;
    b     = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_fail++; $display("FAIL abort_diff got=%h exp=00", diff); end
    n_cmp++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL abort_borrow got=%b exp=0", borrow); end
    n_done = 0;
    repeat (3 * W) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_arith();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
